gfx_clip_pixel: RTL
===================

Name: gfx_clip_pixel

Overview:
- Pixel back-end stage directly downstream of the text blitter.
- Takes one pixel slot per strobe (x, y, draw flag, colour) and clips it against the clip rectangle and target surface.
- Computes the byte address and byte lanes of surviving pixels and queues them as MDW-wide masked writes for the memory arbiter.
- Returns exactly one ack per strobe; the blitter's clip_ack_i is driven from this ack.

Parameters:
- point_width, 16, coordinate width.
- MDW, 256, memory data width in bits (32/64/128/256).
- ALOW, log2(MDW/8), byte-lane address bits.
- FIFO_DEPTH, 4, output write queue entries (power of 2, >=2).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- pix_stb_i  in  1  one-cycle strobe: pixel slot presented.
- pix_write_i  in  1  draw flag for this slot (0 = skip, still acked).
- pix_x_i  in  point_width  pixel x.
- pix_y_i  in  point_width  pixel y.
- color_i  in  32  foreground colour.
- pix_ack_o  out  1  one-cycle ack per strobe.
- clip_en_i  in  1  enable clip rectangle.
- clip_ul_x_i, clip_ul_y_i, clip_lr_x_i, clip_lr_y_i  in  point_width each  clip rectangle; lower-right is exclusive.
- target_base_i  in  32  surface byte base address.
- target_x_size_i, target_y_size_i  in  point_width each  surface size in pixels.
- color_depth_i  in  2  00 = 8bpp, 01 = 16bpp, 10/11 = 32bpp.
- mem_req_o  out  1  write request (queue not empty).
- mem_ack_i  in  1  pops the queue head.
- mem_adr_o  out  32  MDW-aligned address of head.
- mem_sel_o  out  MDW/8  byte enables of head.
- mem_dat_o  out  MDW  data of head.
- stat_clr_i  in  1  clear statistics.
- stat_drawn_o, stat_clipped_o  out  32 each  statistics counters.

Behaviour:
- Reset (rst_i low, any time): FSM to ST_IDLE, queue emptied, pix_ack_o=0, mem_req_o=0, mem_adr_o/mem_sel_o/mem_dat_o=0, stats=0. An in-flight pixel is dropped and is not acked.
- States: ST_IDLE, ST_CLIP, ST_MUL, ST_ADDR, ST_PUSH, ST_ACK.
- ST_IDLE: on pix_stb_i, latch x, y, write, colour and colour depth, then go to ST_CLIP. A strobe in any other state is ignored; upstream must not issue one before the ack.
- ST_CLIP: inside = (x<target_x_size && y<target_y_size) && (!clip_en_i || (x>=ul_x && x<lr_x && y>=ul_y && y<lr_y)), all comparisons unsigned.
  - write && inside: go to ST_MUL.
  - Otherwise go to ST_ACK. Count the pixel as clipped only when write=1 and outside.
- ST_MUL: prod[31:0] <= y*target_x_size (unsigned, truncated to 32 bits).
- ST_ADDR: shift = 0/1/2 by colour depth; badr <= target_base + ((prod + x) << shift), modulo 2^32.
- ST_PUSH:
  - If the queue is not full at the start of the cycle, push {badr with low ALOW bits zeroed, sel, dat}, count drawn, go to ST_ACK. If full, hold in ST_PUSH.
  - sel: 1/2/4 consecutive ones at lane badr[ALOW-1:0]; 16/32bpp are assumed naturally aligned.
  - dat: colour[7:0], [15:0] or [31:0] replicated across MDW.
- ST_ACK: pix_ack_o=1 for exactly this cycle, then go to ST_IDLE.
- Latency (strobe in cycle n):
  - Skipped or clipped pixel: ack in n+2.
  - Drawn pixel with queue space: ack in n+5, plus one cycle per full-stall cycle.
- Queue:
  - Show-ahead FIFO; mem_* outputs reflect the head; mem_req_o = !empty.
  - mem_ack_i while empty is ignored.
  - Push and pop in the same cycle: count unchanged. Pointers wrap modulo FIFO_DEPTH.
  - No bypass: a push into an empty queue is visible the cycle after the push.
- Stat counters wrap at 2^32. stat_clr_i clears both counters and has priority over a simultaneous increment.

Optional Feature:
- GFX_CLIP_STATS_EN
  - Defined: stat_drawn_o and stat_clipped_o count as described above.
  - Undefined: counter logic is removed, both outputs are tied to 0 and stat_clr_i is ignored.
  - Ports exist in both builds.

Test Plan:
- 8bpp, base 0x1000, x_size 640, clip off; strobe x=5 y=2 write=1 colour 0xAB -> ack at n+5; queue entry adr 0x1500, byte 0x1505 -> lane 5; sel bit 5 only; dat all bytes 0xAB.
- write=0, x=5 y=2 -> ack at n+2; no queue entry; stats unchanged.
- clip_en=1, rect (10,10)-(20,20):
  - x=20 y=15 -> clipped (exclusive edge); ack at n+2; stat_clipped=1.
  - x=10 y=10 -> drawn.
- 32bpp, mem_ack_i held 0; 4 drawn strobes fill the queue; 5th waits in ST_PUSH with no ack -> one mem_ack_i pulse -> 5th acks 2 cycles later.
- Pull rst_i low while in ST_MUL -> mem_req_o=0 at once; no ack; after release, a new strobe behaves normally.
- With GFX_CLIP_STATS_EN: 3 drawn + 2 clipped -> 3/2; pulse stat_clr_i on the same cycle as a push -> both 0.

Source files
------------

// File: rtl/gfx_clip_pixel.sv
// Pixel clip/address stage: clips one blitter pixel per strobe and queues MDW-wide masked writes.
// Define GFX_CLIP_STATS_EN to build the drawn/clipped statistics counters.
module gfx_clip_pixel #(
    parameter int unsigned point_width = 16,
    parameter int unsigned MDW         = 256,
    parameter int unsigned ALOW        = $clog2(MDW / 8),
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   pix_stb_i,
    input  logic                   pix_write_i,
    input  logic [point_width-1:0] pix_x_i,
    input  logic [point_width-1:0] pix_y_i,
    input  logic [31:0]            color_i,
    output logic                   pix_ack_o,
    input  logic                   clip_en_i,
    input  logic [point_width-1:0] clip_ul_x_i,
    input  logic [point_width-1:0] clip_ul_y_i,
    input  logic [point_width-1:0] clip_lr_x_i,
    input  logic [point_width-1:0] clip_lr_y_i,
    input  logic [31:0]            target_base_i,
    input  logic [point_width-1:0] target_x_size_i,
    input  logic [point_width-1:0] target_y_size_i,
    input  logic [1:0]             color_depth_i,
    output logic                   mem_req_o,
    input  logic                   mem_ack_i,
    output logic [31:0]            mem_adr_o,
    output logic [MDW/8-1:0]       mem_sel_o,
    output logic [MDW-1:0]         mem_dat_o,
    input  logic                   stat_clr_i,
    output logic [31:0]            stat_drawn_o,
    output logic [31:0]            stat_clipped_o
);

    localparam int unsigned SW = MDW / 8;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FullCnt = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StClip, StMul, StAddr, StPush, StAck} state_e;

    state_e                 state_q;
    logic [point_width-1:0] x_q, y_q;
    logic                   write_q;
    logic [31:0]            color_q;
    logic [1:0]             depth_q;
    logic [31:0]            prod_q;
    logic [31:0]            badr_q;
    logic                   ack_q;

    logic [31:0]   adr_mem [FIFO_DEPTH];
    logic [SW-1:0] sel_mem [FIFO_DEPTH];
    logic [MDW-1:0] dat_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;

    logic in_surface, in_clip, keep, clip_evt;
    logic full, push, pop;
    logic [1:0]     shift;
    logic [ALOW-1:0] lane;
    logic [SW-1:0]  sel_base, push_sel;
    logic [MDW-1:0] push_dat;

    assign in_surface = (x_q < target_x_size_i) && (y_q < target_y_size_i);
    assign in_clip    = !clip_en_i || (x_q >= clip_ul_x_i && x_q < clip_lr_x_i &&
                                       y_q >= clip_ul_y_i && y_q < clip_lr_y_i);
    assign keep       = in_surface && in_clip;
    assign clip_evt   = (state_q == StClip) && write_q && !keep;

    assign full = (count_q == FullCnt);
    assign push = (state_q == StPush) && !full;
    assign pop  = mem_ack_i && (count_q != '0);

    always_comb begin
        shift    = 2'd2;
        sel_base = SW'(15);
        push_dat = {(MDW / 32){color_q}};
        case (depth_q)
            2'b00: begin
                shift    = 2'd0;
                sel_base = SW'(1);
                push_dat = {SW{color_q[7:0]}};
            end
            2'b01: begin
                shift    = 2'd1;
                sel_base = SW'(3);
                push_dat = {(MDW / 16){color_q[15:0]}};
            end
            default: ;
        endcase
        lane     = badr_q[ALOW-1:0];
        push_sel = sel_base << lane;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            write_q <= 1'b0;
            color_q <= '0;
            depth_q <= '0;
            prod_q  <= '0;
            badr_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (pix_stb_i) begin
                        x_q     <= pix_x_i;
                        y_q     <= pix_y_i;
                        write_q <= pix_write_i;
                        color_q <= color_i;
                        depth_q <= color_depth_i;
                        state_q <= StClip;
                    end
                end
                StClip: begin
                    if (write_q && keep) begin
                        state_q <= StMul;
                    end else begin
                        state_q <= StAck;
                        ack_q   <= 1'b1;
                    end
                end
                StMul: begin
                    prod_q  <= 32'(y_q) * 32'(target_x_size_i);
                    state_q <= StAddr;
                end
                StAddr: begin
                    badr_q  <= target_base_i + ((prod_q + 32'(x_q)) << shift);
                    state_q <= StPush;
                end
                StPush: begin
                    // Fullness is judged before any same-cycle pop takes effect.
                    if (!full) begin
                        state_q <= StAck;
                        ack_q   <= 1'b1;
                    end
                end
                StAck:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                adr_mem[i] <= '0;
                sel_mem[i] <= '0;
                dat_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                adr_mem[wr_ptr_q] <= {badr_q[31:ALOW], {ALOW{1'b0}}};
                sel_mem[wr_ptr_q] <= push_sel;
                dat_mem[wr_ptr_q] <= push_dat;
                wr_ptr_q          <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (PW + 1)'(1);
                2'b01:   count_q <= count_q - (PW + 1)'(1);
                default: ;
            endcase
        end
    end

    assign pix_ack_o = ack_q;
    assign mem_req_o = (count_q != '0);
    assign mem_adr_o = adr_mem[rd_ptr_q];
    assign mem_sel_o = sel_mem[rd_ptr_q];
    assign mem_dat_o = dat_mem[rd_ptr_q];

`ifdef GFX_CLIP_STATS_EN
    logic [31:0] drawn_q, clipped_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            drawn_q   <= '0;
            clipped_q <= '0;
        end else if (stat_clr_i) begin
            drawn_q   <= '0;
            clipped_q <= '0;
        end else begin
            if (push)     drawn_q   <= drawn_q + 32'd1;
            if (clip_evt) clipped_q <= clipped_q + 32'd1;
        end
    end

    assign stat_drawn_o   = drawn_q;
    assign stat_clipped_o = clipped_q;
`else
    logic unused_stat;
    assign unused_stat    = stat_clr_i ^ clip_evt;
    assign stat_drawn_o   = '0;
    assign stat_clipped_o = '0;
`endif

endmodule
